// File: rtl/cache_redundant_sram.sv
// N-way redundant single-port SRAM for the cache data path.
// Every copy is written through its own copy mask. Read data is compared
// across the copies (with a bitwise 2-of-3 vote when there are three), and
// each disagreement is flagged and counted. An init FSM zero-fills all
// copies after reset or on request.
module cache_redundant_sram #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_DEPTH    = 256,
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_COPIES    = 2,
  parameter int OUT_REGS      = 0,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                             Clk_CI,
  input  logic                             Rst_RBI,
  input  logic                             CSel_SI,
  input  logic                             WrEn_SI,
  input  logic [DATA_WIDTH/8-1:0]          BEn_SI,
  input  logic [NUM_COPIES-1:0]            WrCopyMask_SI,
  input  logic [DATA_WIDTH-1:0]            WrData_DI,
  input  logic [ADDR_WIDTH-1:0]            Addr_DI,
  input  logic                             InitStart_SI,
  input  logic                             ErrCntClr_SI,
  output logic                             Ready_SO,
  output logic                             RdValid_SO,
  output logic [DATA_WIDTH-1:0]            RdData_DO,
  output logic [NUM_COPIES*DATA_WIDTH-1:0] RdDataAll_DO,
  output logic                             Mismatch_SO,
  output logic [NUM_COPIES-1:0]            MismatchMask_SO,
  output logic [ERR_CNT_WIDTH-1:0]         ErrCnt_DO
);

  localparam int                  BE_W      = DATA_WIDTH / 8;
  localparam int                  ALL_W     = NUM_COPIES * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Bitwise 2-of-3 vote over three copies of a word.
  function automatic logic [DATA_WIDTH-1:0] majority3(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic                    ready_q, ready_d;
  logic                    init_we_s;

  logic [DATA_WIDTH-1:0]   sram_mem [NUM_COPIES][DATA_DEPTH];

  logic                    in_range_s, acc_s, wr_s, rd_s;
  logic [DATA_WIDTH-1:0]   rd_copy_s [NUM_COPIES];
  logic [ALL_W-1:0]        rd_all_s;
  logic [DATA_WIDTH-1:0]   res_data_s;
  logic [NUM_COPIES-1:0]   res_mask_s;

  // First read stage (always present).
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [ALL_W-1:0]        rd_all_q, rd_all_d;
  logic                    rd_mm_q, rd_mm_d;
  logic [NUM_COPIES-1:0]   rd_mask_q, rd_mask_d;

  // Values presented on the output ports (stage 1 or optional stage 2).
  logic                    out_valid_s;
  logic [DATA_WIDTH-1:0]   out_data_s;
  logic [ALL_W-1:0]        out_all_s;
  logic                    out_mm_s;
  logic [NUM_COPIES-1:0]   out_mask_s;

  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Init FSM next state: walk the address space zero-filling, then serve accesses.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_we_s   = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we_s = 1'b1;
        if (init_addr_q == LAST_ADDR) begin
          state_d     = ST_READY;
          init_addr_d = ADDR_WIDTH'(0);
        end else begin
          init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (InitStart_SI) begin
          state_d     = ST_INIT;
          init_addr_d = ADDR_WIDTH'(0);
        end else begin
          state_d     = ST_READY;
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = ADDR_WIDTH'(0);
      end
    endcase
    ready_d = (state_d == ST_READY);
  end

  // FSM and ready flag registers; reset restarts the zero-fill from address 0.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q     <= ST_INIT;
      init_addr_q <= ADDR_WIDTH'(0);
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      ready_q     <= ready_d;
    end
  end

  // Access decode: requests are only taken while ready; writes outside the array are dropped.
  always_comb begin
    in_range_s = ({1'b0, Addr_DI} < DEPTH_EXT);
    acc_s      = CSel_SI & ready_q;
    wr_s       = acc_s & WrEn_SI & in_range_s;
    rd_s       = acc_s & ~WrEn_SI;
  end

  // Array write port: init zero-fill or masked, byte-enabled write per copy.
  always_ff @(posedge Clk_CI) begin
    for (int k = 0; k < NUM_COPIES; k++) begin
      if (init_we_s) begin
        sram_mem[k][init_addr_q] <= {DATA_WIDTH{1'b0}};
      end else if (wr_s && WrCopyMask_SI[k]) begin
        for (int i = 0; i < BE_W; i++) begin
          if (BEn_SI[i]) begin
            sram_mem[k][Addr_DI][i*8 +: 8] <= WrData_DI[i*8 +: 8];
          end
        end
      end
    end
  end

  // Raw per-copy read; an out-of-range address reads as all zeros in every copy.
  always_comb begin
    rd_all_s = {ALL_W{1'b0}};
    for (int k = 0; k < NUM_COPIES; k++) begin
      if (in_range_s) begin
        rd_copy_s[k] = sram_mem[k][Addr_DI];
      end else begin
        rd_copy_s[k] = {DATA_WIDTH{1'b0}};
      end
      rd_all_s[k*DATA_WIDTH +: DATA_WIDTH] = rd_copy_s[k];
    end
  end

  if (NUM_COPIES == 3) begin : g_vote
    // Three copies: vote per bit and flag each copy that differs from the vote.
    always_comb begin
      res_data_s = majority3(rd_copy_s[0], rd_copy_s[1], rd_copy_s[2]);
      res_mask_s = {NUM_COPIES{1'b0}};
      for (int k = 0; k < NUM_COPIES; k++) begin
        res_mask_s[k] = (rd_copy_s[k] != res_data_s);
      end
    end
  end else begin : g_pair
    // Two copies: no way to tell which one is wrong, so both are flagged.
    always_comb begin
      res_data_s = rd_copy_s[0];
      res_mask_s = {NUM_COPIES{rd_copy_s[0] != rd_copy_s[1]}};
    end
  end

  // First read stage: capture on a read, hold data otherwise, flags qualified by valid.
  always_comb begin
    rd_valid_d = rd_s;
    if (rd_s) begin
      rd_data_d = res_data_s;
      rd_all_d  = rd_all_s;
      rd_mm_d   = |res_mask_s;
      rd_mask_d = res_mask_s;
    end else begin
      rd_data_d = rd_data_q;
      rd_all_d  = rd_all_q;
      rd_mm_d   = 1'b0;
      rd_mask_d = {NUM_COPIES{1'b0}};
    end
  end

  // First read stage registers.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      rd_all_q   <= {ALL_W{1'b0}};
      rd_mm_q    <= 1'b0;
      rd_mask_q  <= {NUM_COPIES{1'b0}};
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_all_q   <= rd_all_d;
      rd_mm_q    <= rd_mm_d;
      rd_mask_q  <= rd_mask_d;
    end
  end

  if (OUT_REGS != 0) begin : g_out_reg
    logic                  o_valid_q;
    logic [DATA_WIDTH-1:0] o_data_q;
    logic [ALL_W-1:0]      o_all_q;
    logic                  o_mm_q;
    logic [NUM_COPIES-1:0] o_mask_q;

    // Second read stage: the first stage already holds its data, so a plain copy keeps hold semantics.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
        o_valid_q <= 1'b0;
        o_data_q  <= {DATA_WIDTH{1'b0}};
        o_all_q   <= {ALL_W{1'b0}};
        o_mm_q    <= 1'b0;
        o_mask_q  <= {NUM_COPIES{1'b0}};
      end else begin
        o_valid_q <= rd_valid_q;
        o_data_q  <= rd_data_q;
        o_all_q   <= rd_all_q;
        o_mm_q    <= rd_mm_q;
        o_mask_q  <= rd_mask_q;
      end
    end

    assign out_valid_s = o_valid_q;
    assign out_data_s  = o_data_q;
    assign out_all_s   = o_all_q;
    assign out_mm_s    = o_mm_q;
    assign out_mask_s  = o_mask_q;
  end else begin : g_out_direct
    assign out_valid_s = rd_valid_q;
    assign out_data_s  = rd_data_q;
    assign out_all_s   = rd_all_q;
    assign out_mm_s    = rd_mm_q;
    assign out_mask_s  = rd_mask_q;
  end

  // Mismatch counter: counts presented mismatching reads, saturates, clear has priority.
  always_comb begin
    if (ErrCntClr_SI) begin
      err_cnt_d = {ERR_CNT_WIDTH{1'b0}};
    end else if (out_valid_s && out_mm_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Mismatch counter register; survives re-initialisation.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      err_cnt_q <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Ready_SO        = ready_q;
  assign RdValid_SO      = out_valid_s;
  assign RdData_DO       = out_data_s;
  assign RdDataAll_DO    = out_all_s;
  assign Mismatch_SO     = out_mm_s;
  assign MismatchMask_SO = out_mask_s;
  assign ErrCnt_DO       = err_cnt_q;

endmodule

// File: tb/tb_cache_redundant_sram.sv
// Bench for cache_redundant_sram: two instances (2 copies / 1-cycle latency / 256 words,
// and 3 copies / 2-cycle latency / 200 words / 2-bit counter) share stimulus and are
// compared every cycle against a word-level reference model.
module tb_cache_redundant_sram;

  logic        clk = 1'b0;
  logic        rst_n, csel, wren, init_start, clr;
  logic [7:0]  ben, addr;
  logic [63:0] wdata;
  logic [1:0]  wmask0;
  logic [2:0]  wmask1;

  logic          rdy0, vld0, mm0;
  logic [63:0]   dat0;
  logic [127:0]  all0;
  logic [1:0]    msk0;
  logic [15:0]   cnt0;

  logic          rdy1, vld1, mm1;
  logic [63:0]   dat1;
  logic [191:0]  all1;
  logic [2:0]    msk1;
  logic [1:0]    cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_redundant_sram #(.ADDR_WIDTH(8), .DATA_DEPTH(256), .DATA_WIDTH(64), .NUM_COPIES(2),
                         .OUT_REGS(0), .ERR_CNT_WIDTH(16)) u_dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .CSel_SI(csel), .WrEn_SI(wren), .BEn_SI(ben),
    .WrCopyMask_SI(wmask0), .WrData_DI(wdata), .Addr_DI(addr), .InitStart_SI(init_start),
    .ErrCntClr_SI(clr), .Ready_SO(rdy0), .RdValid_SO(vld0), .RdData_DO(dat0),
    .RdDataAll_DO(all0), .Mismatch_SO(mm0), .MismatchMask_SO(msk0), .ErrCnt_DO(cnt0));

  cache_redundant_sram #(.ADDR_WIDTH(8), .DATA_DEPTH(200), .DATA_WIDTH(64), .NUM_COPIES(3),
                         .OUT_REGS(1), .ERR_CNT_WIDTH(2)) u_dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .CSel_SI(csel), .WrEn_SI(wren), .BEn_SI(ben),
    .WrCopyMask_SI(wmask1), .WrData_DI(wdata), .Addr_DI(addr), .InitStart_SI(init_start),
    .ErrCntClr_SI(clr), .Ready_SO(rdy1), .RdValid_SO(vld1), .RdData_DO(dat1),
    .RdDataAll_DO(all1), .Mismatch_SO(mm1), .MismatchMask_SO(msk1), .ErrCnt_DO(cnt1));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic         v;
    logic [63:0]  d;
    logic [191:0] all;
    logic         mm;
    logic [2:0]   mask;
  } rd_t;

  int   m_nc    [2] = '{2, 3};
  int   m_depth [2] = '{256, 200};
  int   m_lat   [2] = '{1, 2};
  int   m_cmax  [2] = '{65535, 3};

  logic [63:0] m_mem [2][3][256];
  bit          m_ready [2];
  int          m_iaddr [2];
  int          m_cnt   [2];
  rd_t         m_out   [2];
  rd_t         m_pipe  [2];

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rd_t advance(input rd_t old, input rd_t in);
    rd_t r;
    r   = old;
    r.v = in.v;
    if (in.v) begin
      r.d = in.d; r.all = in.all; r.mm = in.mm; r.mask = in.mask;
    end else begin
      r.mm = 1'b0; r.mask = 3'b000;
    end
    return r;
  endfunction

  // Word-level resolution: copy 0 for a pair, per-bit vote count for three copies.
  function automatic rd_t resolve(input int i, input int a);
    rd_t r;
    logic [63:0] c [3];
    int votes;
    r = '0;
    r.v = 1'b1;
    for (int k = 0; k < 3; k++) c[k] = 64'h0;
    if (a < m_depth[i]) begin
      for (int k = 0; k < m_nc[i]; k++) c[k] = m_mem[i][k][a];
    end
    for (int k = 0; k < m_nc[i]; k++) r.all[k*64 +: 64] = c[k];
    if (m_nc[i] == 2) begin
      r.d    = c[0];
      r.mm   = (c[0] != c[1]);
      r.mask = r.mm ? 3'b011 : 3'b000;
    end else begin
      for (int j = 0; j < 64; j++) begin
        votes = int'(c[0][j]) + int'(c[1][j]) + int'(c[2][j]);
        r.d[j] = (votes >= 2);
      end
      for (int k = 0; k < 3; k++) r.mask[k] = (c[k] != r.d);
      r.mm = (r.mask != 3'b000);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ready[i] = 1'b0; m_iaddr[i] = 0; m_cnt[i] = 0;
      m_out[i] = '0; m_pipe[i] = '0;
    end
  endtask

  // Effect of one rising clock edge with the inputs currently driven.
  task automatic model_edge();
    rd_t r;
    logic [2:0] wm;
    for (int i = 0; i < 2; i++) begin
      wm = (i == 0) ? {1'b0, wmask0} : wmask1;
      if (clr) m_cnt[i] = 0;
      else if (m_out[i].v && m_out[i].mm && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
      r = '0;
      if (csel && m_ready[i] && !wren) r = resolve(i, int'(addr));
      if (csel && m_ready[i] && wren && int'(addr) < m_depth[i]) begin
        for (int k = 0; k < m_nc[i]; k++)
          if (wm[k])
            for (int b = 0; b < 8; b++)
              if (ben[b]) m_mem[i][k][addr][b*8 +: 8] = wdata[b*8 +: 8];
      end
      if (!m_ready[i]) begin
        for (int k = 0; k < m_nc[i]; k++) m_mem[i][k][m_iaddr[i]] = 64'h0;
        if (m_iaddr[i] == m_depth[i] - 1) begin
          m_ready[i] = 1'b1; m_iaddr[i] = 0;
        end else m_iaddr[i]++;
      end else if (init_start) begin
        m_ready[i] = 1'b0; m_iaddr[i] = 0;
      end
      if (m_lat[i] == 1) m_out[i] = advance(m_out[i], r);
      else begin
        m_out[i]  = advance(m_out[i], m_pipe[i]);
        m_pipe[i] = advance(m_pipe[i], r);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("rdy0", rdy0, m_ready[0]);
    check_eq("vld0", vld0, m_out[0].v);
    check_eq("dat0", dat0, m_out[0].d);
    check_eq("all0", all0, m_out[0].all);
    check_eq("mm0",  mm0,  m_out[0].mm);
    check_eq("msk0", msk0, m_out[0].mask);
    check_eq("cnt0", cnt0, m_cnt[0]);
    check_eq("rdy1", rdy1, m_ready[1]);
    check_eq("vld1", vld1, m_out[1].v);
    check_eq("dat1", dat1, m_out[1].d);
    check_eq("all1", all1, m_out[1].all);
    check_eq("mm1",  mm1,  m_out[1].mm);
    check_eq("msk1", msk1, m_out[1].mask);
    check_eq("cnt1", cnt1, m_cnt[1]);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    csel = 1'b0; wren = 1'b0; ben = 8'h00; addr = 8'h00; wdata = 64'h0;
    wmask0 = 2'b11; wmask1 = 3'b111; init_start = 1'b0; clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_all();
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be,
                       input logic [1:0] m0, input logic [2:0] m1);
    csel = 1'b1; wren = 1'b1; addr = a; wdata = d; ben = be; wmask0 = m0; wmask1 = m1;
    tick();
    set_idle();
  endtask

  task automatic start_rd(input logic [7:0] a);
    csel = 1'b1; wren = 1'b0; addr = a;
    tick();
    set_idle();
  endtask

  task automatic rand_inputs(input int lo_addr, input bit faults);
    csel  = ($urandom_range(0, 3) != 0);
    wren  = $urandom_range(0, 1) == 1;
    addr  = 8'($urandom_range(lo_addr, 255));
    wdata = {$urandom, $urandom};
    ben   = 8'($urandom);
    wmask0 = (faults && $urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
    wmask1 = (faults && $urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
    init_start = faults && ($urandom_range(0, 299) == 0);
    clr   = faults && ($urandom_range(0, 99) == 0);
  endtask

  // Counts ticks until instance 0 reports ready, with traffic that must be dropped.
  task automatic wait_ready0(output int n);
    n = 0;
    while (!rdy0 && n < 1000) begin
      rand_inputs(16, 1'b0);
      tick();
      n++;
    end
    set_idle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    set_idle();
    rst_n = 1'b1;
    #2;
    apply_reset();
    check_eq("reset_rdy0", rdy0, 1'b0);

    wait_ready0(n);
    check_eq("init_len", n, 256);

    // Highest in-range address of instance 0 (out of range for instance 1).
    start_rd(8'd255);
    check_eq("rd255_vld0", vld0, 1'b1);
    check_eq("rd255_dat0", dat0, 64'h0);
    tick();
    check_eq("rd255_vld1", vld1, 1'b1);
    check_eq("rd255_dat1", all1, 192'h0);
    check_eq("rd255_mm1", mm1, 1'b0);

    // Byte-enable merge.
    do_wr(8'd5, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b11, 3'b111);
    do_wr(8'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 2'b11, 3'b111);
    start_rd(8'd5);
    check_eq("ben_dat0", dat0, 64'h0123_4567_89AB_CDFF);
    tick();
    check_eq("ben_dat1", dat1, 64'h0123_4567_89AB_CDFF);

    // Single-copy writes: pair mismatch, vote outvotes the faulty copy.
    do_wr(8'd7, 64'hAA, 8'hFF, 2'b01, 3'b001);
    start_rd(8'd7);
    check_eq("pair_dat0", dat0, 64'hAA);
    check_eq("pair_mm0", mm0, 1'b1);
    check_eq("pair_msk0", msk0, 2'b11);
    tick();
    check_eq("pair_cnt0", cnt0, 16'd1);

    do_wr(8'd3, 64'h5, 8'hFF, 2'b11, 3'b010);
    start_rd(8'd3);
    tick();
    check_eq("vote1_dat1", dat1, 64'h0);
    check_eq("vote1_msk1", msk1, 3'b010);
    do_wr(8'd3, 64'h5, 8'hFF, 2'b11, 3'b110);
    start_rd(8'd3);
    tick();
    check_eq("vote2_dat1", dat1, 64'h5);
    check_eq("vote2_msk1", msk1, 3'b001);

    // Saturation of the 2-bit counter, then clear colliding with increments.
    clr = 1'b1; tick(); tick(); clr = 1'b0;
    for (int r = 0; r < 5; r++) begin
      csel = 1'b1; wren = 1'b0; addr = 8'd7;
      tick();
    end
    set_idle();
    tick(); tick();
    check_eq("sat_cnt1", cnt1, 2'd3);
    check_eq("sat_cnt0", cnt0, 16'd5);
    start_rd(8'd7);
    clr = 1'b1;
    tick();
    check_eq("clr_cnt0", cnt0, 16'd0);
    tick();
    check_eq("clr_cnt1", cnt1, 2'd0);
    clr = 1'b0;
    tick();

    // Re-init request with a same-cycle write.
    do_wr(8'd9, 64'hDEAD_BEEF, 8'hFF, 2'b11, 3'b111);
    init_start = 1'b1; csel = 1'b1; wren = 1'b1; addr = 8'd9; wdata = 64'h1234; ben = 8'hFF;
    tick();
    set_idle();
    check_eq("initreq_rdy0", rdy0, 1'b0);
    wait_ready0(n);
    check_eq("reinit_len", n, 256);
    start_rd(8'd9);
    check_eq("reinit_dat0", dat0, 64'h0);

    // Reset in the middle of init restarts the full fill.
    init_start = 1'b1; tick(); set_idle();
    for (int c = 0; c < 50; c++) tick();
    apply_reset();
    wait_ready0(n);
    check_eq("rstinit_len", n, 256);

    // Randomized traffic with occasional faults, re-inits and clears.
    for (int c = 0; c < 800; c++) begin
      rand_inputs(0, 1'b1);
      tick();
    end
    set_idle();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_redundant_sram.md
Name: cache_redundant_sram

Overview:
N-way redundant single-port SRAM for the cache data path. It generalises the fixed two-copy arrangement to a parametric copy count and data width. Per-copy write masking is included for fault injection. Read data is compared across copies, with 3-way bitwise majority voting when NUM_COPIES=3. Mismatches are flagged and counted, and a built-in init FSM zero-fills all copies after reset or on request. It sits between the cache controller and the data arrays; S²QED-style checks observe RdDataAll_DO and Mismatch_SO.

Parameters:
ADDR_WIDTH, 8, address bits
DATA_DEPTH, 256, words per copy, must be <= 2**ADDR_WIDTH
DATA_WIDTH, 64, word width, must be a multiple of 8
NUM_COPIES, 2, redundant copies, legal values 2 or 3
OUT_REGS, 0, 1 adds one output register stage
ERR_CNT_WIDTH, 16, width of the mismatch counter

Ports:
Clk_CI  in  1  clock, rising edge
Rst_RBI  in  1  asynchronous active-low reset
CSel_SI  in  1  access request
WrEn_SI  in  1  1=write, 0=read
BEn_SI  in  DATA_WIDTH/8  byte enables for writes
WrCopyMask_SI  in  NUM_COPIES  copies a write applies to; all-ones in normal operation
WrData_DI  in  DATA_WIDTH  write data
Addr_DI  in  ADDR_WIDTH  word address
InitStart_SI  in  1  pulse that requests re-initialisation
ErrCntClr_SI  in  1  clears ErrCnt_DO
Ready_SO  out  1  high when accesses are accepted
RdValid_SO  out  1  read data valid
RdData_DO  out  DATA_WIDTH  resolved read data
RdDataAll_DO  out  NUM_COPIES*DATA_WIDTH  raw per-copy data, copy k at bits [k*DATA_WIDTH +: DATA_WIDTH]
Mismatch_SO  out  1  copies disagreed on this read
MismatchMask_SO  out  NUM_COPIES  copies that disagree
ErrCnt_DO  out  ERR_CNT_WIDTH  saturating mismatch count

Behaviour:
- Reset (asynchronous, any time, including mid-init or mid-read):
  - All outputs go to 0 and the read pipeline is flushed.
  - FSM enters INIT at address 0. Array contents are not reset directly.
- FSM states:
  - INIT: writes zeros to address a in all copies, one address per cycle, for a = 0..DATA_DEPTH-1. Ready_SO=0.
  - INIT to READY on the cycle after address DATA_DEPTH-1 is written, so Ready_SO rises DATA_DEPTH cycles after reset release.
  - READY: Ready_SO=1. InitStart_SI=1 moves to INIT at address 0 on the next edge. A same-cycle access is still performed.
  - InitStart_SI is ignored while in INIT.
- Accesses occur only when CSel_SI=1 and Ready_SO=1. While Ready_SO=0 they are dropped silently: no write, no RdValid_SO.
- Write:
  - Byte i of copy k is updated iff BEn_SI[i] and WrCopyMask_SI[k].
  - No RdValid_SO is generated. Write-then-read of the same address returns the new data.
- Read:
  - RdValid_SO and the data outputs appear 1+OUT_REGS cycles after the request edge. Back-to-back reads are accepted every cycle.
  - RdValid_SO=0 on all other cycles. Data outputs hold their last value when RdValid_SO=0.
- Out-of-range address (Addr_DI >= DATA_DEPTH):
  - Writes are dropped.
  - Reads return RdValid_SO=1 with all data 0 and Mismatch_SO=0.
- Resolution, NUM_COPIES=2:
  - RdData_DO = copy0.
  - Mismatch_SO = (copy0 != copy1). MismatchMask_SO = 2'b11 on mismatch, else 0.
- Resolution, NUM_COPIES=3:
  - RdData_DO = bitwise majority (c0&c1 | c0&c2 | c1&c2).
  - MismatchMask_SO[k] = (copy k != majority). Mismatch_SO = |MismatchMask_SO.
- Mismatch_SO and MismatchMask_SO are qualified by RdValid_SO (0 when RdValid_SO=0).
- ErrCnt_DO:
  - Increments by 1 on each cycle with RdValid_SO and Mismatch_SO both high.
  - Saturates at all-ones.
  - If ErrCntClr_SI and an increment occur in the same cycle, the clear wins and the counter goes to 0.
  - The counter is not cleared by INIT, only by reset or ErrCntClr_SI.

Test Plan:
- Release reset with DATA_DEPTH=256 -> Ready_SO=0 for exactly 256 cycles, then 1. A read of addr 255 returns 0 with Mismatch_SO=0. Repeat with OUT_REGS=1 and check latency is 2.
- Write 0x0123_4567_89AB_CDEF to addr 5 with BEn=0xFF, then write 0xFF.. with BEn=0x01, then read -> 0x0123_4567_89AB_CDFF one cycle later with RdValid_SO=1.
- NUM_COPIES=2: write 0xAA to addr 7 with WrCopyMask=2'b01, then read -> RdData_DO=0xAA, Mismatch_SO=1, mask=2'b11, ErrCnt_DO=1.
- NUM_COPIES=3: write 0x5 to addr 3 with mask=3'b010, then read -> RdData_DO=0, mask=3'b010. Next, write 0x5 with mask=3'b110 and read -> RdData_DO=0x5, mask=3'b001.
- ERR_CNT_WIDTH=2: 5 mismatching reads -> ErrCnt_DO saturates at 3. Assert ErrCntClr_SI on the cycle of a mismatching read -> counter is 0.
- InitStart_SI in READY, with a write issued to addr 9 in the same cycle -> Ready_SO drops next cycle and reads during INIT are dropped. After 256 cycles, addr 9 reads 0. Asserting Rst_RBI mid-INIT restarts the full 256-cycle init.
